// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 key sequencer.
//   - scan-code constants for the prefix bytes, the discard bytes and the modifier keys
//   - FSM state enum and the decode classification of a received byte
//   - bit positions inside the mods vector {caps_lock, alt, ctrl, rshift, lshift}
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_NUL    = 8'h00;
  localparam logic [7:0] SC_ERR    = 8'hFF;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam int MOD_W      = 5;
  localparam int MOD_LSHIFT = 0;
  localparam int MOD_RSHIFT = 1;
  localparam int MOD_CTRL   = 2;
  localparam int MOD_ALT    = 3;
  localparam int MOD_CAPS   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_DECODE = 2'd2,
    ST_EMIT   = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    CLS_EXT     = 2'd0,
    CLS_BRK     = 2'd1,
    CLS_DISCARD = 2'd2,
    CLS_KEY     = 2'd3
  } byte_class_e;

  // Sort a received byte into prefix / discard / real key code.
  function automatic byte_class_e classify(input logic [7:0] b);
    byte_class_e c;
    case (b)
      SC_EXT:  c = CLS_EXT;
      SC_BRK:  c = CLS_BRK;
      SC_NUL:  c = CLS_DISCARD;
      SC_ERR:  c = CLS_DISCARD;
      SC_BAT:  c = CLS_DISCARD;
      default: c = CLS_KEY;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ps2_key_sequencer_if.sv
// ps2_key_sequencer_if: bundle of the receiver-side FIFO signals and the
// consumer-side event handshake.
//   kbd_data/kbd_ready/kbd_overflow : receiver FIFO head, non-empty, overflow
//   kbd_rdn                         : active-low pop strobe back to the receiver
//   ev_valid/ev_ack                 : event handshake with the consumer
//   ev_code/ev_ext/ev_break         : event payload
//   mods                            : live {caps_lock, alt, ctrl, rshift, lshift}
//   err                             : sticky overflow/timeout flag
// master = the sequencer, slave = receiver plus consumer.
interface ps2_key_sequencer_if;
  import ps2_pkg::*;

  logic [7:0]       kbd_data;
  logic             kbd_ready;
  logic             kbd_overflow;
  logic             kbd_rdn;
  logic             ev_valid;
  logic             ev_ack;
  logic [7:0]       ev_code;
  logic             ev_ext;
  logic             ev_break;
  logic [MOD_W-1:0] mods;
  logic             err;

  modport master (
    input  kbd_data, kbd_ready, kbd_overflow, ev_ack,
    output kbd_rdn, ev_valid, ev_code, ev_ext, ev_break, mods, err
  );

  modport slave (
    output kbd_data, kbd_ready, kbd_overflow, ev_ack,
    input  kbd_rdn, ev_valid, ev_code, ev_ext, ev_break, mods, err
  );

endinterface

// File: rtl/ps2_mod_tracker.sv
// ps2_mod_tracker: modifier and Caps Lock state, updated once per decoded key.
//   clk, clrn  : clock, synchronous active-low reset
//   code_i     : final scan code of the key event
//   ext_i      : event carried the 0xE0 prefix
//   brk_i      : event carried the 0xF0 prefix (release)
//   strobe_i   : one-cycle pulse when a key event is decoded
//   mods_o     : registered {caps_lock, alt, ctrl, rshift, lshift}
module ps2_mod_tracker
  import ps2_pkg::*;
(
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       code_i,
  input  logic             ext_i,
  input  logic             brk_i,
  input  logic             strobe_i,
  output logic [MOD_W-1:0] mods_o
);

  logic [MOD_W-1:0] mods_q, mods_d;
  logic             caps_held_q, caps_held_d;

  // Next modifier state from the strobed key event.
  always_comb begin
    mods_d      = mods_q;
    caps_held_d = caps_held_q;
    if (strobe_i) begin
      case (code_i)
        SC_LSHIFT: begin
          if (!ext_i) begin
            mods_d[MOD_LSHIFT] = ~brk_i;
          end else begin
            mods_d[MOD_LSHIFT] = mods_q[MOD_LSHIFT];
          end
        end
        SC_RSHIFT: begin
          if (!ext_i) begin
            mods_d[MOD_RSHIFT] = ~brk_i;
          end else begin
            mods_d[MOD_RSHIFT] = mods_q[MOD_RSHIFT];
          end
        end
        SC_CTRL: mods_d[MOD_CTRL] = ~brk_i;
        SC_ALT:  mods_d[MOD_ALT]  = ~brk_i;
        SC_CAPS: begin
          // caps_held suppresses re-toggling on typematic repeats of the make code.
          if (ext_i) begin
            caps_held_d = caps_held_q;
          end else if (brk_i) begin
            caps_held_d = 1'b0;
          end else begin
            if (!caps_held_q) begin
              mods_d[MOD_CAPS] = ~mods_q[MOD_CAPS];
            end else begin
              mods_d[MOD_CAPS] = mods_q[MOD_CAPS];
            end
            caps_held_d = 1'b1;
          end
        end
        default: mods_d = mods_q;
      endcase
    end else begin
      mods_d      = mods_q;
      caps_held_d = caps_held_q;
    end
  end

  // Modifier and caps-held registers.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      mods_q      <= {MOD_W{1'b0}};
      caps_held_q <= 1'b0;
    end else begin
      mods_q      <= mods_d;
      caps_held_q <= caps_held_d;
    end
  end

  assign mods_o = mods_q;

endmodule

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: drains the PS/2 receiver FIFO, folds E0/F0 prefixes into
// single key events and presents them on a valid/ack handshake.
//   clk, clrn : 25 MHz clock, synchronous active-low reset
//   bus       : ps2_key_sequencer_if.master (receiver FIFO, pop strobe,
//               event handshake/payload, mods, sticky err)
// Parameters: TIMEOUT_CYC cycles a pending prefix may wait for its next byte,
// TO_W width of the timeout counter.
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2_500_000,
  parameter int TO_W        = 22
)(
  input  logic                  clk,
  input  logic                  clrn,
  ps2_key_sequencer_if.master   bus
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

  seq_state_e       state_q;
  logic [7:0]       byte_q;
  logic             ext_p_q, brk_p_q;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             to_fire_s;
  logic             kbd_rdn_q;
  logic             ev_valid_q;
  logic [7:0]       ev_code_q;
  logic             ev_ext_q, ev_break_q;
  logic             err_q;
  byte_class_e      cls_s;
  logic             ext_eff_s, brk_eff_s, key_stb_s;
  logic [MOD_W-1:0] mods_s;

  // Byte classification; an overflow in the decode cycle truncates the prefixes it would use.
  always_comb begin
    cls_s     = classify(byte_q);
    ext_eff_s = ext_p_q & ~bus.kbd_overflow;
    brk_eff_s = brk_p_q & ~bus.kbd_overflow;
    key_stb_s = (state_q == ST_DECODE) && (cls_s == CLS_KEY);
  end

  // Prefix timeout counter: runs only while idle with a prefix pending, cleared by a byte latch.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    to_fire_s = 1'b0;
    if ((state_q == ST_IDLE) && bus.kbd_ready) begin
      to_cnt_d = {TO_W{1'b0}};
    end else if ((state_q == ST_IDLE) && (ext_p_q || brk_p_q)) begin
      if (to_cnt_q == TO_LAST) begin
        to_cnt_d  = {TO_W{1'b0}};
        to_fire_s = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_ONE;
      end
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // Sequencer FSM with registered pop strobe, event payload, prefix flags and error flag.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q    <= ST_IDLE;
      byte_q     <= 8'h00;
      ext_p_q    <= 1'b0;
      brk_p_q    <= 1'b0;
      to_cnt_q   <= {TO_W{1'b0}};
      kbd_rdn_q  <= 1'b1;
      ev_valid_q <= 1'b0;
      ev_code_q  <= 8'h00;
      ev_ext_q   <= 1'b0;
      ev_break_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      case (state_q)
        ST_IDLE: begin
          kbd_rdn_q <= 1'b1;
          if (bus.kbd_ready) begin
            byte_q    <= bus.kbd_data;
            // Strobe goes low for exactly the POP cycle.
            kbd_rdn_q <= 1'b0;
            state_q   <= ST_POP;
          end
        end
        ST_POP: begin
          kbd_rdn_q <= 1'b1;
          state_q   <= ST_DECODE;
        end
        ST_DECODE: begin
          kbd_rdn_q <= 1'b1;
          case (cls_s)
            CLS_EXT: begin
              ext_p_q <= 1'b1;
              state_q <= ST_IDLE;
            end
            CLS_BRK: begin
              brk_p_q <= 1'b1;
              state_q <= ST_IDLE;
            end
            CLS_DISCARD: begin
              ext_p_q <= 1'b0;
              brk_p_q <= 1'b0;
              state_q <= ST_IDLE;
            end
            CLS_KEY: begin
              ev_code_q  <= byte_q;
              ev_ext_q   <= ext_eff_s;
              ev_break_q <= brk_eff_s;
              ev_valid_q <= 1'b1;
              state_q    <= ST_EMIT;
            end
            default: state_q <= ST_IDLE;
          endcase
        end
        ST_EMIT: begin
          kbd_rdn_q <= 1'b1;
          if (bus.ev_ack) begin
            ev_valid_q <= 1'b0;
            ext_p_q    <= 1'b0;
            brk_p_q    <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          kbd_rdn_q  <= 1'b1;
          ev_valid_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
      // Overflow or timeout overrides any prefix update made above this cycle.
      if (bus.kbd_overflow || to_fire_s) begin
        ext_p_q <= 1'b0;
        brk_p_q <= 1'b0;
        err_q   <= 1'b1;
      end
    end
  end

  ps2_mod_tracker u_mods (
    .clk      (clk),
    .clrn     (clrn),
    .code_i   (byte_q),
    .ext_i    (ext_eff_s),
    .brk_i    (brk_eff_s),
    .strobe_i (key_stb_s),
    .mods_o   (mods_s)
  );

  assign bus.kbd_rdn  = kbd_rdn_q;
  assign bus.ev_valid = ev_valid_q;
  assign bus.ev_code  = ev_code_q;
  assign bus.ev_ext   = ev_ext_q;
  assign bus.ev_break = ev_break_q;
  assign bus.mods     = mods_s;
  assign bus.err      = err_q;

endmodule
